alu_hazard_ctrl: RTL



---
 rtl/alu_hazard_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/alu_hazard_ctrl.sv
// EX-stage pipeline controller: flag register, jump resolution/flush, load-use stall, operand forwarding.
// Optional feature macro ALU_HAZARD_FWD_EN: defined = registered forwarding selects; undefined = stall on any RAW.
module alu_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       id_valid,
  input  logic [2:0] id_rs1,
  input  logic [2:0] id_rs2,
  input  logic [2:0] ex_rd,
  input  logic [2:0] mem_rd,
  input  logic [2:0] wb_rd,
  input  logic       ex_wb,
  input  logic       mem_wb,
  input  logic       wb_wb,
  input  logic       ex_mem_read,
  input  logic [1:0] ex_jump_type,
  input  logic       ex_flags_we,
  input  logic       alu_carry,
  input  logic       alu_zero,
  input  logic       alu_neg,
  output logic [2:0] flags_q,
  output logic       jump_taken,
  output logic       flush_if_id,
  output logic       stall,
  output logic       bubble,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic       jump_cond, load_use, hazard;
  logic       jump_d, flush_d, stall_d, bubble_d;

  // Jump conditions read only the committed flags, never this cycle's ALU flags.
  always_comb begin
    jump_cond = 1'b0;
    case (ex_jump_type)
      2'd1:    jump_cond = flags_q[1];
      2'd2:    jump_cond = flags_q[0];
      2'd3:    jump_cond = flags_q[2];
      default: jump_cond = 1'b0;
    endcase
  end

  assign load_use = id_valid & ex_mem_read & ex_wb & ((ex_rd == id_rs1) | (ex_rd == id_rs2));

`ifdef ALU_HAZARD_FWD_EN
  logic unused_wb;
  assign unused_wb = ^{wb_rd, wb_wb};
  assign hazard    = load_use;
`else
  logic raw_hit;
  always_comb begin
    raw_hit = 1'b0;
    if (id_valid) begin
      raw_hit = (ex_wb  & ((ex_rd  == id_rs1) | (ex_rd  == id_rs2))) |
                (mem_wb & ((mem_rd == id_rs1) | (mem_rd == id_rs2))) |
                (wb_wb  & ((wb_rd  == id_rs1) | (wb_rd  == id_rs2)));
    end
  end
  assign hazard = raw_hit | load_use;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    jump_d   = 1'b0;
    flush_d  = 1'b0;
    stall_d  = 1'b0;
    bubble_d = 1'b0;
    case (state_q)
      RUN: begin
        if (jump_cond) begin
          state_d  = FLUSH;
          cnt_d    = 2'(FLUSH_CYCLES - 1);
          jump_d   = 1'b1;
          flush_d  = 1'b1;
          bubble_d = 1'b1;
        end else if (hazard) begin
          state_d  = STALL;
          stall_d  = 1'b1;
          bubble_d = 1'b1;
        end
      end
      STALL: begin
`ifdef ALU_HAZARD_FWD_EN
        state_d = RUN;
`else
        // Without forwarding the consumer waits until every matching writer has retired.
        if (raw_hit) begin
          stall_d  = 1'b1;
          bubble_d = 1'b1;
        end else begin
          state_d = RUN;
        end
`endif
      end
      FLUSH: begin
        if (cnt_q == 2'd0) begin
          state_d = RUN;
        end else begin
          cnt_d    = cnt_q - 2'd1;
          flush_d  = 1'b1;
          bubble_d = 1'b1;
        end
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      cnt_q       <= 2'd0;
      jump_taken  <= 1'b0;
      flush_if_id <= 1'b0;
      stall       <= 1'b0;
      bubble      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      jump_taken  <= jump_d;
      flush_if_id <= flush_d;
      stall       <= stall_d;
      bubble      <= bubble_d;
    end
  end

  // Wrong-path instructions in EX during a flush must not disturb the flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= 3'b000;
    end else if (ex_flags_we && state_q != FLUSH) begin
      flags_q <= {alu_carry, alu_zero, alu_neg};
    end
  end

`ifdef ALU_HAZARD_FWD_EN
  logic [1:0] fwd_a_d, fwd_b_d;

  // A load in EX has no result yet, so it never forwards from EX/MEM.
  always_comb begin
    fwd_a_d = 2'd0;
    fwd_b_d = 2'd0;
    if (ex_wb && !ex_mem_read && ex_rd == id_rs1) fwd_a_d = 2'd1;
    else if (mem_wb && mem_rd == id_rs1)          fwd_a_d = 2'd2;
    if (ex_wb && !ex_mem_read && ex_rd == id_rs2) fwd_b_d = 2'd1;
    else if (mem_wb && mem_rd == id_rs2)          fwd_b_d = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a <= 2'd0;
      fwd_b <= 2'd0;
    end else if (bubble_d) begin
      fwd_a <= 2'd0;
      fwd_b <= 2'd0;
    end else if (!(state_q == STALL && state_d == STALL)) begin
      fwd_a <= fwd_a_d;
      fwd_b <= fwd_b_d;
    end
  end
`else
  assign fwd_a = 2'd0;
  assign fwd_b = 2'd0;
`endif

endmodule
